// File: rtl/stack_unit.sv
// Downward-growing LIFO responder for the control unit's push/pop handshake.
// Optional macro STACK_PEEK_EN adds a peek_req input (non-destructive read of the top entry).
module stack_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              push_req,
  input  logic              pop_req,
  input  logic [DATA_W-1:0] push_data,
`ifdef STACK_PEEK_EN
  input  logic              peek_req,
`endif
  output logic              push_done,
  output logic              pop_done,
  output logic [DATA_W-1:0] pop_out,
  output logic [15:0]       sp,
  output logic              full,
  output logic              empty,
  output logic              err_overflow,
  output logic              err_underflow,
  output logic [1:0]        dbg_state
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] SP_EMPTY = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] SP_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PUSH_ACK = 2'd1,
    POP_RD   = 2'd2,
    POP_ACK  = 2'd3
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W:0]   sp_q, sp_d;
  logic [DATA_W-1:0] pop_out_q, pop_out_d;
  logic              push_done_q, push_done_d;
  logic              pop_done_q, pop_done_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_udf_q, err_udf_d;
`ifdef STACK_PEEK_EN
  logic              peek_q, peek_d;
`endif

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [ADDR_W:0]   sp_dec;
  logic [ADDR_W:0]   sp_inc;

  assign sp_dec = sp_q - SP_ONE;
  assign sp_inc = sp_q + SP_ONE;

  // Handshake: requests are level signals sampled only in IDLE; push_done/pop_done
  // are registered one-cycle pulses, and the requester drops req by the edge
  // that ends the done cycle (a req still high in the next IDLE is a new request).
  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    pop_out_d   = pop_out_q;
    push_done_d = 1'b0;
    pop_done_d  = 1'b0;
    err_ovf_d   = err_ovf_q;
    err_udf_d   = err_udf_q;
    mem_we      = 1'b0;
    mem_waddr   = sp_dec[ADDR_W-1:0];
`ifdef STACK_PEEK_EN
    peek_d      = peek_q;
`endif
    case (state_q)
      IDLE: begin
        if (push_req) begin
          state_d     = PUSH_ACK;
          push_done_d = 1'b1;
          if (sp_q == '0) begin
            err_ovf_d = 1'b1;
          end else begin
            mem_we = 1'b1;
            sp_d   = sp_dec;
          end
        end else if (pop_req) begin
          state_d = POP_RD;
`ifdef STACK_PEEK_EN
          peek_d  = 1'b0;
        end else if (peek_req) begin
          state_d = POP_RD;
          peek_d  = 1'b1;
`endif
        end
      end
      POP_RD: begin
        state_d    = POP_ACK;
        pop_done_d = 1'b1;
        if (sp_q == SP_EMPTY) begin
          pop_out_d = '0;
          err_udf_d = 1'b1;
        end else begin
          pop_out_d = mem[sp_q[ADDR_W-1:0]];
`ifdef STACK_PEEK_EN
          if (!peek_q) sp_d = sp_inc;
`else
          sp_d = sp_inc;
`endif
        end
      end
      POP_ACK:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q     <= IDLE;
      sp_q        <= SP_EMPTY;
      pop_out_q   <= '0;
      push_done_q <= 1'b0;
      pop_done_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_udf_q   <= 1'b0;
`ifdef STACK_PEEK_EN
      peek_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      pop_out_q   <= pop_out_d;
      push_done_q <= push_done_d;
      pop_done_q  <= pop_done_d;
      err_ovf_q   <= err_ovf_d;
      err_udf_q   <= err_udf_d;
`ifdef STACK_PEEK_EN
      peek_q      <= peek_d;
`endif
    end
  end

  // Memory is deliberately not reset; reset only suppresses an in-flight write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst_b) mem[mem_waddr] <= push_data;
  end

  assign push_done     = push_done_q;
  assign pop_done      = pop_done_q;
  assign pop_out       = pop_out_q;
  assign sp            = 16'(sp_q);
  assign full          = (sp_q == '0);
  assign empty         = (sp_q == SP_EMPTY);
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_udf_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: drivers queue expected done responses, a negedge
// monitor pops and compares them whenever push_done/pop_done is seen.
module tb_stack_unit;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        push_req;
  logic        pop_req;
  logic [15:0] push_data;
  logic        push_done;
  logic        pop_done;
  logic [15:0] pop_out;
  logic [15:0] sp;
  logic        full;
  logic        empty;
  logic        err_overflow;
  logic        err_underflow;
  logic [1:0]  dbg_state;
`ifdef STACK_PEEK_EN
  logic        peek_req;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // {is_pop, expected pop_out, expected sp}
  logic [32:0] exp_q[$];

  stack_unit #(.DATA_W(16), .ADDR_W(6)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .push_req     (push_req),
    .pop_req      (pop_req),
    .push_data    (push_data),
`ifdef STACK_PEEK_EN
    .peek_req     (peek_req),
`endif
    .push_done    (push_done),
    .pop_done     (pop_done),
    .pop_out      (pop_out),
    .sp           (sp),
    .full         (full),
    .empty        (empty),
    .err_overflow (err_overflow),
    .err_underflow(err_underflow),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (push_done || pop_done) begin
      logic [32:0] e;
      check("single_done", {31'b0, push_done & pop_done}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("done_kind", {31'b0, pop_done}, {31'b0, e[32]});
        if (pop_done) check("pop_out", {16'b0, pop_out}, {16'b0, e[31:16]});
        check("done_sp", {16'b0, sp}, {16'b0, e[15:0]});
      end
    end
  end

  task automatic push_op(input logic [15:0] data, input logic [15:0] exp_sp);
    int n;
    @(negedge clk);
    exp_q.push_back({1'b0, 16'h0, exp_sp});
    push_data = data;
    push_req  = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!push_done && n < 8);
    push_req = 1'b0;
    check("push_latency", n, 1);
  endtask

  task automatic pop_op(input logic [15:0] exp_data, input logic [15:0] exp_sp, input bit peek);
    int n;
    @(negedge clk);
    exp_q.push_back({1'b1, exp_data, exp_sp});
`ifdef STACK_PEEK_EN
    if (peek) peek_req = 1'b1; else pop_req = 1'b1;
`else
    pop_req = 1'b1;
`endif
    n = 0;
    do begin @(negedge clk); n++; end while (!pop_done && n < 8);
    pop_req = 1'b0;
`ifdef STACK_PEEK_EN
    peek_req = 1'b0;
`endif
    check(peek ? "peek_latency" : "pop_latency", n, 2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_b = 1'b1;
    push_req = 1'b0;
    pop_req = 1'b0;
    push_data = '0;
`ifdef STACK_PEEK_EN
    peek_req = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_sp", sp, 64);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_pop_out", pop_out, 0);
    check("rst_dones", {push_done, pop_done}, 0);
    check("rst_errs", {err_overflow, err_underflow}, 0);
    check("rst_state", dbg_state, 0);
    rst_b = 1'b0;

    // Basic LIFO order
    push_op(16'h1234, 63);
    push_op(16'hBEEF, 62);
    push_op(16'h00A5, 61);
    pop_op(16'h00A5, 62, 0);
    pop_op(16'hBEEF, 63, 0);
    pop_op(16'h1234, 64, 0);
    check("lifo_empty", empty, 1);

    // Fill to full, then overflow
    for (int i = 0; i < 64; i++) push_op(16'(i), 16'(63 - i));
    check("fill_full", full, 1);
    check("fill_sp", sp, 0);
    check("fill_ovf_clear", err_overflow, 0);
    push_op(16'hFFFF, 0);
    check("ovf_flag", err_overflow, 1);
    check("ovf_sp", sp, 0);
    pop_op(16'h003F, 1, 0);
    for (int k = 0; k < 63; k++) pop_op(16'(62 - k), 16'(2 + k), 0);
    check("drain_empty", empty, 1);
    check("drain_udf_clear", err_underflow, 0);

    // Underflow, sticky flags
    pop_op(16'h0000, 64, 0);
    check("udf_flag", err_underflow, 1);
    push_op(16'h0042, 63);
    pop_op(16'h0042, 64, 0);
    check("udf_sticky", err_underflow, 1);
    check("ovf_sticky", err_overflow, 1);

    // Simultaneous requests: push wins, pop served next IDLE
    @(negedge clk);
    exp_q.push_back({1'b0, 16'h0, 16'd63});
    exp_q.push_back({1'b1, 16'h5555, 16'd64});
    push_data = 16'h5555;
    push_req = 1'b1;
    pop_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!push_done && n < 8);
    push_req = 1'b0;
    check("both_push_latency", n, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!pop_done && n < 8);
    pop_req = 1'b0;
    check("both_pop_latency", n, 3);

    // Reset in POP_RD
    push_op(16'h1111, 63);
    @(negedge clk);
    pop_req = 1'b1;
    @(negedge clk);
    check("pre_rst_state", dbg_state, 2);
    rst_b = 1'b1;
    pop_req = 1'b0;
    @(negedge clk);
    check("mid_rst_state", dbg_state, 0);
    check("mid_rst_sp", sp, 64);
    check("mid_rst_pop_out", pop_out, 0);
    check("mid_rst_errs", {err_overflow, err_underflow}, 0);
    rst_b = 1'b0;
    n = 0;
    repeat (4) begin @(negedge clk); if (pop_done) n++; end
    check("mid_rst_no_done", n, 0);

`ifdef STACK_PEEK_EN
    push_op(16'h7777, 63);
    pop_op(16'h7777, 63, 1);
    check("peek_sp", sp, 63);
    pop_op(16'h7777, 64, 0);
    pop_op(16'h0000, 64, 1);
    check("peek_udf", err_underflow, 1);
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
